// File: rtl/data_memory_responder.sv
// Wait-stated SRAM responder for the stage-4 load/store port.
// Accepts one request at a time and returns a single-cycle mem_ready pulse.
module data_memory_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_en,
   output logic [31:0] read_data,
   output logic        mem_ready,
   output logic        mem_stall,
   output logic        addr_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   localparam logic [3:0] CNT_INIT =
      4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t r_state;
   state_t w_next;

   logic [3:0]            r_cnt;
   logic                  r_we;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;
   logic [31:0]           r_rdata;
   logic [31:0]           r_mem [2**ADDR_WIDTH];

   logic                  w_start;
   logic                  w_err;
   logic                  w_access;
   logic                  w_acc_we;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [ADDR_WIDTH-1:0] w_acc_idx;
   logic [31:0]           w_acc_wdata;
   logic [3:0]            w_acc_be;

   assign w_idx   = mem_addr[ADDR_WIDTH+1:2];
   assign w_err   = (mem_addr[1:0] != 2'b00) |
                    ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
   assign w_start = (r_state == S_IDLE) & mem_req;

   // Zero-wait accesses complete on the accepting edge, so use live inputs.
   assign w_acc_we    = (r_state == S_IDLE) ? mem_we     : r_we;
   assign w_acc_idx   = (r_state == S_IDLE) ? w_idx      : r_idx;
   assign w_acc_wdata = (r_state == S_IDLE) ? write_data : r_wdata;
   assign w_acc_be    = (r_state == S_IDLE) ? byte_en    : r_be;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_access = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (mem_req) begin
               if (w_err) begin
                  w_next = S_RESP;
               end else if (WAIT_STATES == 0) begin
                  w_next   = S_RESP;
                  w_access = 1'b1;
               end else begin
                  w_next = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) begin
               w_next   = S_RESP;
               w_access = 1'b1;
            end
         end
         S_RESP: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
      end else if (w_start) begin
         r_cnt   <= CNT_INIT;
         r_we    <= mem_we;
         r_err   <= w_err;
         r_idx   <= w_idx;
         r_wdata <= write_data;
         r_be    <= byte_en;
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 32'd0;
      end else if (w_access && !w_acc_we) begin
         r_rdata <= r_mem[w_acc_idx];
      end
   end

   // Array has no reset; writes land only on the completing edge.
   always_ff @(posedge clk) begin
      if (rst_n && w_access && w_acc_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_acc_be[i]) begin
               r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign read_data  = r_rdata;
   assign mem_ready  = (r_state == S_RESP);
   assign addr_error = (r_state == S_RESP) & r_err;
   assign mem_stall  = (r_state == S_BUSY) |
                       ((r_state == S_IDLE) & mem_req);

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed cases plus randomized
// traffic against a word-array reference model.
module tb_data_memory_responder;

   logic        clk;
   logic        rst_n;
   logic        mem_req;
   logic        mem_req0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] write_data;
   logic [3:0]  byte_en;
   logic [31:0] read_data;
   logic        mem_ready;
   logic        mem_stall;
   logic        addr_error;
   logic [31:0] read_data0;
   logic        mem_ready0;
   logic        mem_stall0;
   logic        addr_error0;

   int errs;
   int checks;

   logic [31:0] m_mem [1024];
   logic [31:0] m_rd;

   data_memory_responder #(
      .ADDR_WIDTH  (10),
      .WAIT_STATES (2)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .byte_en    (byte_en),
      .read_data  (read_data),
      .mem_ready  (mem_ready),
      .mem_stall  (mem_stall),
      .addr_error (addr_error)
   );

   data_memory_responder #(
      .ADDR_WIDTH  (10),
      .WAIT_STATES (0)
   ) u_dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_req    (mem_req0),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .byte_en    (byte_en),
      .read_data  (read_data0),
      .mem_ready  (mem_ready0),
      .mem_stall  (mem_stall0),
      .addr_error (addr_error0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One request on the WAIT_STATES=2 instance, starting just after a
   // rising edge; returns just after the edge that ends the RESP cycle.
   task automatic xfer(input bit          we,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [3:0]  be,
                       input bit          perturb);
      bit err;
      bit got;
      int lat;
      err = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
      mem_we     = we;
      mem_addr   = addr;
      write_data = wd;
      byte_en    = be;
      mem_req    = 1'b1;
      got = 1'b0;
      lat = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (mem_ready) begin
            got = 1'b1;
            lat = c;
         end else begin
            check("stall_wait", {31'd0, mem_stall}, 32'd1);
            if (perturb && c == 1) begin
               mem_addr   = $urandom & 32'h0000_0FFC;
               write_data = $urandom;
               byte_en    = 4'hF;
               mem_we     = ~we;
            end
         end
      end
      mem_req = 1'b0;
      if (!got) begin
         check("timeout", 32'd0, 32'd1);
      end else begin
         check("latency", lat, err ? 32'd1 : 32'd3);
         check("stall_resp", {31'd0, mem_stall}, 32'd0);
         check("addr_error", {31'd0, addr_error}, {31'd0, err});
         if (!err) begin
            if (we) begin
               for (int i = 0; i < 4; i++)
                  if (be[i]) m_mem[addr[11:2]][8*i +: 8] = wd[8*i +: 8];
            end else begin
               m_rd = m_mem[addr[11:2]];
            end
         end
         check("read_data", read_data, m_rd);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      bit          rw;
      int          op;
      errs     = 0;
      checks   = 0;
      m_rd     = 32'd0;
      rst_n    = 1'b0;
      mem_req  = 1'b0;
      mem_req0 = 1'b0;
      mem_we   = 1'b0;
      mem_addr = 32'd0;
      write_data = 32'd0;
      byte_en  = 4'd0;
      for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, mem_ready}, 32'd0);
      check("rst_stall", {31'd0, mem_stall}, 32'd0);
      check("rst_aerr", {31'd0, addr_error}, 32'd0);
      check("rst_rdata", read_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++)
         xfer(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);

      xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      xfer(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
      check("t1_rdata", read_data, 32'hDEADBEEF);

      xfer(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
      xfer(1'b0, 32'h10, 32'd0, 4'hF, 1'b0);
      check("t2_be1", read_data, 32'hDEADBEAA);
      xfer(1'b1, 32'h10, 32'h1234_0000, 4'b1100, 1'b0);
      xfer(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
      check("t2_be12", read_data, 32'h1234BEAA);
      xfer(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
      xfer(1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
      check("t2_be0", read_data, 32'h1234BEAA);

      xfer(1'b0, 32'h13, 32'd0, 4'h0, 1'b0);
      check("t3_mis_rd", read_data, 32'h1234BEAA);
      xfer(1'b1, 32'h1000, 32'h0BAD_0BAD, 4'hF, 1'b0);
      xfer(1'b0, 32'h0, 32'd0, 4'h0, 1'b0);

      // Reset while the store to 0x20 is still in BUSY.
      mem_we     = 1'b1;
      mem_addr   = 32'h20;
      write_data = 32'h55;
      byte_en    = 4'hF;
      mem_req    = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("t4_busy", {31'd0, mem_stall}, 32'd1);
      mem_req = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("t4_ready", {31'd0, mem_ready}, 32'd0);
      check("t4_stall", {31'd0, mem_stall}, 32'd0);
      check("t4_aerr", {31'd0, addr_error}, 32'd0);
      check("t4_rdata", read_data, 32'd0);
      m_rd = 32'd0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      xfer(1'b0, 32'h20, 32'd0, 4'h0, 1'b0);

      xfer(1'b1, 32'h24, 32'h600D_F00D, 4'hF, 1'b1);
      xfer(1'b0, 32'h24, 32'd0, 4'h0, 1'b1);
      check("t6_rdata", read_data, 32'h600D_F00D);

      for (int n = 0; n < 80; n++) begin
         op = $urandom_range(0, 9);
         rw = 1'($urandom);
         a  = 32'($urandom_range(0, 15) * 4);
         if (op == 0) a = a | 32'($urandom_range(1, 3));
         if (op == 1) a = a | 32'h0000_1000;
         xfer(rw, a, $urandom, 4'($urandom), 1'($urandom));
      end

      // Zero wait states: store, then a load held for four cycles.
      mem_we     = 1'b1;
      mem_addr   = 32'h44;
      write_data = 32'hCAFE_F00D;
      byte_en    = 4'hF;
      mem_req0   = 1'b1;
      @(negedge clk);
      check("t5_st_stall", {31'd0, mem_stall0}, 32'd1);
      check("t5_st_wait", {31'd0, mem_ready0}, 32'd0);
      @(negedge clk);
      check("t5_st_ready", {31'd0, mem_ready0}, 32'd1);
      mem_req0 = 1'b0;
      @(posedge clk);
      #1;
      mem_we   = 1'b0;
      mem_req0 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("t5_ready", {31'd0, mem_ready0},
               (c == 1 || c == 3) ? 32'd1 : 32'd0);
         check("t5_stall", {31'd0, mem_stall0},
               (c == 0 || c == 2) ? 32'd1 : 32'd0);
         if (c == 1 || c == 3) begin
            check("t5_rdata", read_data0, 32'hCAFE_F00D);
            check("t5_aerr", {31'd0, addr_error0}, 32'd0);
         end
      end
      mem_req0 = 1'b0;
      @(posedge clk);
      #1;
      check("t5_idle_rdy", {31'd0, mem_ready0}, 32'd0);
      check("t5_idle_stl", {31'd0, mem_stall0}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
